branch_predictor_btb: RTL and testbench
=======================================

# branch_predictor_btb

Parametrised, set-associative branch target buffer with per-entry saturating direction counters, LRU replacement, mispredict detection and saturating hit/mispredict statistics. Sits beside the fetch stage: it answers a combinational lookup for the current fetch PC every cycle and takes one resolved-branch update per cycle from the EX/MEM boundary. On a mispredict it drives the pipeline flush lines and the redirect PC to the hazard unit.

## Interface
- ENTRIES, 16: total entries, power of two, ≥ WAYS
- WAYS, 2: associativity, 1 or 2
- CTR_W, 2: direction counter width, 1–3
- STAT_W, 16: statistics counter width
- Derived: SETS = ENTRIES/WAYS; IDX_W = log2(SETS); TAG_W = 30 − IDX_W. Addresses are 30-bit word addresses (PC[31:2]).

- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock, synchronous and active-high
- lookup_pc  in  30  fetch word address
- pred_hit  out  1  valid tag match in lookup set
- pred_taken  out  1  pred_hit & counter MSB
- pred_target  out  30  stored target on hit, else 0
- upd_en  in  1  resolved branch this cycle
- upd_pc  in  30  branch word address
- upd_taken  in  1  actual outcome
- upd_target  in  30  actual target
- upd_pred_taken  in  1  prediction carried down the pipe
- upd_pred_target  in  30  predicted target carried down the pipe
- invalidate  in  1  clear all valid bits
- mispredict  out  1  resolved branch disagrees with prediction
- redirect_pc  out  30  correct next fetch address
- flush_ifid, flush_idex, flush_exmem  out  1 each  all equal mispredict
- hit_count, mispredict_count  out  STAT_W  statistics

## Operation
- Per entry: valid, tag[TAG_W], target[30], ctr[CTR_W]. Per set: lru (WAYS=2 only; lru = way to evict next).
- Index = addr[IDX_W-1:0]; tag = addr[29:IDX_W].
- Lookup (combinational): hit if any valid way tag matches; if both ways match (never created by this block), way 0 wins.
- mispredict = upd_en & ((upd_taken ≠ upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target ≠ upd_pred_target)). Combinational.
- redirect_pc = upd_taken ? upd_target : upd_pc + 1 (30-bit wrap: 0x3FFFFFFF → 0). Equals 0 when mispredict = 0.
- Update (registered on CLK, when upd_en):
  - Hit in upd set: target ← upd_target; ctr +1 if taken (saturate at 2^CTR_W−1), −1 if not taken (saturate at 0); lru ← other way.
  - Miss, upd_taken = 1: allocate way = lowest invalid way, else lru way; write valid=1, tag, target, ctr = 2^(CTR_W−1) (weakly taken); lru ← other way.
  - Miss, upd_taken = 0: no table change.
- Statistics (registered, saturate at all-ones, never wrap): hit_count +1 each cycle pred_hit = 1; mispredict_count +1 each cycle mispredict = 1.
- invalidate: all valid ← 0 next edge; ctr, tag, target, lru, statistics untouched. If upd_en in the same cycle, invalidate wins (no write).
- Reset: valid, tag, target, ctr, lru, statistics all 0. RST overrides upd_en and invalidate.

## Timing
- Lookup outputs: zero latency from lookup_pc and current table state.
- Updates visible to lookup on the cycle after the write edge. Lookup and update to the same entry in the same cycle: lookup returns pre-update contents.
- mispredict, flush_*, redirect_pc: zero latency from upd_* inputs; asserted only in the upd_en cycle; independent of table state.
- One update per cycle; back-to-back updates to one entry each see the prior write.
- After RST deasserts: pred_hit = 0 for every PC, mispredict = 0 unless upd_en, counts = 0.

## Test plan
- Reset, then lookup_pc 0x100 → pred_hit 0, pred_target 0, hit_count stays 0.
- Update pc 0x100 taken target 0x200, pred_taken 0 → same cycle mispredict 1, all flushes 1, redirect 0x200; next cycle lookup 0x100 → hit 1, taken 1 (ctr 2), target 0x200, mispredict_count 1.
- Three not-taken updates on 0x100 → ctr 2→1→0→0 (saturates); pred_taken 0 from the first; upd_pc 0x3FFFFFFF not-taken mispredict → redirect 0.
- ENTRIES 16, WAYS 2: taken updates to 0x008, 0x108, 0x208 (same set 0) → third evicts 0x008; 0x108, 0x208 hit, 0x008 misses.
- invalidate together with upd_en → no allocation; all lookups miss the next cycle; counts unchanged.
- Hold lookup on a hit for 2^STAT_W+5 cycles → hit_count stuck at 0xFFFF (STAT_W 16).

Source files
------------

// File: rtl/branch_predictor_btb_if.sv
// Bundles the BTB fetch lookup, resolved-branch update, flush/redirect and statistics lines.
// Latency: none, this is a pure signal bundle.
// Backpressure: none; one lookup and one update are accepted every cycle.
interface branch_predictor_btb_if #(
  parameter int STAT_W = 16
);
  logic [29:0]       lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [29:0]       pred_target;
  logic              upd_en;
  logic [29:0]       upd_pc;
  logic              upd_taken;
  logic [29:0]       upd_target;
  logic              upd_pred_taken;
  logic [29:0]       upd_pred_target;
  logic              invalidate;
  logic              mispredict;
  logic [29:0]       redirect_pc;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic [STAT_W-1:0] hit_count;
  logic [STAT_W-1:0] mispredict_count;

  // Pipeline side: drives fetch PC and resolved branches, consumes predictions.
  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, invalidate,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           flush_ifid, flush_idex, flush_exmem, hit_count, mispredict_count
  );

  // BTB side.
  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, invalidate,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           flush_ifid, flush_idex, flush_exmem, hit_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Set-associative BTB with saturating direction counters, LRU, mispredict/redirect and stats.
// Latency: lookup and mispredict are combinational; table and stats update on the next edge.
// Backpressure: none; one lookup and one resolved-branch update are taken every cycle.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int WAYS    = 2,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  branch_predictor_btb_if.slave bus
);
  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  // Table storage; lru_q names the way to evict next in each set.
  logic              valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [29:0]       target_q [SETS][WAYS];
  logic [CTR_W-1:0]  ctr_q    [SETS][WAYS];
  logic              lru_q    [SETS];

  logic [STAT_W-1:0] hit_q;
  logic [STAT_W-1:0] misp_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              lk_way;

  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              up_way;
  logic              alloc_way;
  logic              wr_way;
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_next;
  logic              misp;

  assign lk_idx = bus.lookup_pc[IDX_W-1:0];
  assign lk_tag = bus.lookup_pc[29:IDX_W];
  assign up_idx = bus.upd_pc[IDX_W-1:0];
  assign up_tag = bus.upd_pc[29:IDX_W];

  // Fetch lookup: scan ways from the top down so way 0 wins a double match.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = 1'(w);
      end
    end
  end

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit & ctr_q[lk_idx][lk_way][CTR_W-1];
  assign bus.pred_target = lk_hit ? target_q[lk_idx][lk_way] : 30'd0;

  // Update-side tag match and victim choice (lowest invalid way, else LRU way).
  always_comb begin
    up_hit    = 1'b0;
    up_way    = 1'b0;
    alloc_way = (WAYS == 2) ? lru_q[up_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = 1'(w);
      end
      if (!valid_q[up_idx][w]) begin
        alloc_way = 1'(w);
      end
    end
  end

  assign wr_way  = up_hit ? up_way : alloc_way;
  assign ctr_cur = ctr_q[up_idx][up_way];

  // Direction counter step, saturating at both ends.
  always_comb begin
    ctr_next = ctr_cur;
    if (bus.upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_W'(1);
    end
  end

  // Mispredict depends only on the resolved branch, never on table state.
  assign misp = bus.upd_en &
                ((bus.upd_taken != bus.upd_pred_taken) |
                 (bus.upd_taken & bus.upd_pred_taken & (bus.upd_target != bus.upd_pred_target)));

  assign bus.mispredict  = misp;
  assign bus.flush_ifid  = misp;
  assign bus.flush_idex  = misp;
  assign bus.flush_exmem = misp;
  assign bus.redirect_pc = !misp          ? 30'd0 :
                           bus.upd_taken ? bus.upd_target : bus.upd_pc + 30'd1;

  // Table write: reset clears everything, invalidate only drops valid bits and blocks the update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= '0;
        end
      end
    end else if (bus.invalidate) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else if (bus.upd_en && (up_hit || bus.upd_taken)) begin
      valid_q[up_idx][wr_way]  <= 1'b1;
      tag_q[up_idx][wr_way]    <= up_tag;
      target_q[up_idx][wr_way] <= bus.upd_target;
      ctr_q[up_idx][wr_way]    <= up_hit ? ctr_next : CTR_INIT;
      if (WAYS == 2) lru_q[up_idx] <= ~wr_way;
    end
  end

  // Statistics, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_q  <= '0;
      misp_q <= '0;
    end else begin
      if (lk_hit && (hit_q != '1))  hit_q  <= hit_q + STAT_W'(1);
      if (misp && (misp_q != '1))   misp_q <= misp_q + STAT_W'(1);
    end
  end

  assign bus.hit_count        = hit_q;
  assign bus.mispredict_count = misp_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES 16, WAYS 2, CTR_W 2, STAT_W 16).
// Inputs change 1 ns after a rising edge, outputs are checked on the falling edge.
// Lookup sits on MISS_PC (never allocated) except in cycles that check a hit.
module tb_branch_predictor_btb;
  localparam logic [29:0] MISS_PC = 30'h3F7;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  int   exp_hits;

  branch_predictor_btb_if #(.STAT_W(16)) bus ();

  branch_predictor_btb #(
    .ENTRIES(16), .WAYS(2), .CTR_W(2), .STAT_W(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.lookup_pc       = MISS_PC;
    bus.upd_en          = 1'b0;
    bus.upd_pc          = 30'd0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = 30'd0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = 30'd0;
    bus.invalidate      = 1'b0;
  endtask

  task automatic drive_upd(input logic [29:0] pc, input logic tk, input logic [29:0] tgt,
                           input logic ptk, input logic [29:0] ptgt);
    bus.upd_en          = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle();
    step();
    step();
    RST = 1'b0;
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0h want 0", bus.pred_hit); end
    checks++; if (bus.pred_target !== 30'd0) begin errors++; $display("FAIL reset_target got %0h want 0", bus.pred_target); end
    checks++; if (bus.mispredict !== 1'b0 || bus.redirect_pc !== 30'd0) begin errors++; $display("FAIL reset_misp got %0h/%0h want 0/0", bus.mispredict, bus.redirect_pc); end
    checks++; if (bus.mispredict_count !== 16'd0) begin errors++; $display("FAIL reset_mcount got %0h want 0", bus.mispredict_count); end
    step();
    idle();
    #4;
    checks++; if (bus.hit_count !== 16'd0) begin errors++; $display("FAIL reset_hcount got %0h want 0", bus.hit_count); end
  endtask

  task automatic test_allocate();
    idle();
    drive_upd(30'h100, 1'b1, 30'h200, 1'b0, 30'h0);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_misp got %0h want 1", bus.mispredict); end
    checks++; if ({bus.flush_ifid, bus.flush_idex, bus.flush_exmem} !== 3'b111) begin errors++; $display("FAIL alloc_flush got %b want 111", {bus.flush_ifid, bus.flush_idex, bus.flush_exmem}); end
    checks++; if (bus.redirect_pc !== 30'h200) begin errors++; $display("FAIL alloc_redirect got %0h want 200", bus.redirect_pc); end
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL alloc_preupdate_hit got %0h want 0", bus.pred_hit); end
    step();
    idle();
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if ({bus.pred_hit, bus.pred_taken} !== 2'b11) begin errors++; $display("FAIL alloc_hit_taken got %b want 11", {bus.pred_hit, bus.pred_taken}); end
    checks++; if (bus.pred_target !== 30'h200) begin errors++; $display("FAIL alloc_target got %0h want 200", bus.pred_target); end
    checks++; if (bus.mispredict_count !== 16'd1) begin errors++; $display("FAIL alloc_mcount got %0h want 1", bus.mispredict_count); end
    checks++; if (bus.mispredict !== 1'b0 || bus.redirect_pc !== 30'd0) begin errors++; $display("FAIL alloc_idle_misp got %0h/%0h want 0/0", bus.mispredict, bus.redirect_pc); end
    checks++; if (bus.hit_count !== 16'd0) begin errors++; $display("FAIL alloc_hcount0 got %0h want 0", bus.hit_count); end
    exp_hits++;
    step();
    idle();
    #4;
    checks++; if (bus.hit_count !== 16'd1) begin errors++; $display("FAIL alloc_hcount1 got %0h want 1", bus.hit_count); end
  endtask

  task automatic test_counter();
    // ctr 2 -> 1: predicted taken, resolved not taken.
    idle();
    drive_upd(30'h100, 1'b0, 30'h0, 1'b1, 30'h200);
    #4;
    checks++; if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 30'h101) begin errors++; $display("FAIL ctr_nt_redirect got %0h/%0h want 1/101", bus.mispredict, bus.redirect_pc); end
    step();
    // ctr 1 -> 0, back-to-back on the same entry.
    idle();
    drive_upd(30'h100, 1'b0, 30'h0, 1'b0, 30'h0);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if ({bus.pred_hit, bus.pred_taken} !== 2'b10) begin errors++; $display("FAIL ctr_1 got %b want 10", {bus.pred_hit, bus.pred_taken}); end
    checks++; if (bus.mispredict !== 1'b0 || bus.redirect_pc !== 30'd0) begin errors++; $display("FAIL ctr_agree_misp got %0h/%0h want 0/0", bus.mispredict, bus.redirect_pc); end
    exp_hits++;
    step();
    // ctr 0 -> 0
    idle();
    drive_upd(30'h100, 1'b0, 30'h0, 1'b0, 30'h0);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_0 got %0h want 0", bus.pred_taken); end
    exp_hits++;
    step();
    // ctr 0 -> 0 again
    idle();
    drive_upd(30'h100, 1'b0, 30'h0, 1'b0, 30'h0);
    step();
    // taken: ctr 0 -> 1 (a wrapped counter would reach 3)
    idle();
    drive_upd(30'h100, 1'b1, 30'h200, 1'b0, 30'h0);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_sat0 got %0h want 0", bus.pred_taken); end
    exp_hits++;
    step();
    // ctr 1 -> 2, predicted correctly
    idle();
    drive_upd(30'h100, 1'b1, 30'h200, 1'b1, 30'h200);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_up1 got %0h want 0", bus.pred_taken); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL ctr_correct_misp got %0h want 0", bus.mispredict); end
    exp_hits++;
    step();
    // taken with wrong target: mispredict, ctr 2 -> 3, target replaced
    idle();
    drive_upd(30'h100, 1'b1, 30'h300, 1'b1, 30'h200);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_up2 got %0h want 1", bus.pred_taken); end
    checks++; if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 30'h300) begin errors++; $display("FAIL tgt_misp got %0h/%0h want 1/300", bus.mispredict, bus.redirect_pc); end
    exp_hits++;
    step();
    // not-taken at the top of the address space: fall-through wraps to 0
    idle();
    drive_upd(30'h3FFFFFFF, 1'b0, 30'h0, 1'b1, 30'h5);
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_target !== 30'h300) begin errors++; $display("FAIL tgt_update got %0h want 300", bus.pred_target); end
    checks++; if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 30'd0) begin errors++; $display("FAIL wrap_redirect got %0h/%0h want 1/0", bus.mispredict, bus.redirect_pc); end
    exp_hits++;
    step();
    idle();
    bus.lookup_pc = 30'h3FFFFFFF;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL nt_noalloc got %0h want 0", bus.pred_hit); end
    checks++; if (bus.mispredict_count !== 16'd5) begin errors++; $display("FAIL ctr_mcount got %0d want 5", bus.mispredict_count); end
    checks++; if (bus.hit_count !== 16'(exp_hits)) begin errors++; $display("FAIL ctr_hcount got %0d want %0d", bus.hit_count, exp_hits); end
    step();
  endtask

  task automatic test_evict();
    logic [29:0] pcs [3];
    logic [29:0] tgts [3];
    pcs[0] = 30'h008; pcs[1] = 30'h108; pcs[2] = 30'h208;
    tgts[0] = 30'h11; tgts[1] = 30'h22; tgts[2] = 30'h33;
    for (int i = 0; i < 3; i++) begin
      idle();
      drive_upd(pcs[i], 1'b1, tgts[i], 1'b0, 30'h0);
      step();
    end
    idle();
    bus.lookup_pc = 30'h108;
    #4;
    checks++; if (bus.pred_hit !== 1'b1 || bus.pred_target !== 30'h22) begin errors++; $display("FAIL evict_108 got %0h/%0h want 1/22", bus.pred_hit, bus.pred_target); end
    exp_hits++;
    step();
    bus.lookup_pc = 30'h208;
    #4;
    checks++; if (bus.pred_hit !== 1'b1 || bus.pred_target !== 30'h33) begin errors++; $display("FAIL evict_208 got %0h/%0h want 1/33", bus.pred_hit, bus.pred_target); end
    exp_hits++;
    step();
    bus.lookup_pc = 30'h008;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL evict_008 got %0h want 0", bus.pred_hit); end
    step();
    bus.lookup_pc = 30'h100;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL evict_100 got %0h want 0", bus.pred_hit); end
    checks++; if (bus.mispredict_count !== 16'd8) begin errors++; $display("FAIL evict_mcount got %0d want 8", bus.mispredict_count); end
    step();
  endtask

  task automatic test_invalidate();
    idle();
    drive_upd(30'h050, 1'b1, 30'h60, 1'b1, 30'h60);
    bus.invalidate = 1'b1;
    bus.lookup_pc  = 30'h108;
    #4;
    checks++; if (bus.pred_hit !== 1'b1) begin errors++; $display("FAIL inv_prehit got %0h want 1", bus.pred_hit); end
    exp_hits++;
    step();
    idle();
    bus.lookup_pc = 30'h108;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL inv_108 got %0h want 0", bus.pred_hit); end
    step();
    bus.lookup_pc = 30'h208;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL inv_208 got %0h want 0", bus.pred_hit); end
    step();
    bus.lookup_pc = 30'h050;
    #4;
    checks++; if (bus.pred_hit !== 1'b0) begin errors++; $display("FAIL inv_noalloc got %0h want 0", bus.pred_hit); end
    checks++; if (bus.mispredict_count !== 16'd8) begin errors++; $display("FAIL inv_mcount got %0d want 8", bus.mispredict_count); end
    checks++; if (bus.hit_count !== 16'(exp_hits)) begin errors++; $display("FAIL inv_hcount got %0d want %0d", bus.hit_count, exp_hits); end
    step();
  endtask

  task automatic test_hit_saturation();
    idle();
    drive_upd(30'h400, 1'b1, 30'h44, 1'b1, 30'h44);
    step();
    idle();
    bus.lookup_pc = 30'h400;
    for (int i = 0; i < 65536 + 5; i++) step();
    idle();
    #4;
    checks++; if (bus.hit_count !== 16'hFFFF) begin errors++; $display("FAIL hit_sat got %0h want ffff", bus.hit_count); end
    checks++; if (bus.mispredict_count !== 16'd8) begin errors++; $display("FAIL sat_mcount got %0d want 8", bus.mispredict_count); end
    step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_hits = 0;
    RST      = 1'b1;
    idle();
    test_reset();
    test_allocate();
    test_counter();
    test_evict();
    test_invalidate();
    test_hit_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
